alu_exec_ctrl: RTL and testbench

- Multi-cycle operand/write-back stage that sits directly upstream of the combinational ALU and consumes its result.
- Accepts register-addressed commands over a valid/ready handshake and reads two operands from an internal 8x32 register file.
- Drives the ALU's alu_a/alu_b/alu_op, captures alu_out, and writes it back to the destination register, reporting the result.
- Gives the lab datapath a sequenced execute loop around the ALU.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_exec_ctrl_if.sv | 38 +++
 rtl/regfile_8x32.sv | 34 +++
 rtl/alu_exec_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_exec_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcode encodings, FSM states
// and default datapath widths.
package alu_pkg;

  localparam int NREG_DEF = 8;
  localparam int DW_DEF   = 32;
  localparam int OPW_DEF  = 5;
  localparam int CW_DEF   = 16;

  // Encodings shared with the combinational ALU downstream.
  localparam logic [OPW_DEF-1:0] A_NOP = 5'h00;
  localparam logic [OPW_DEF-1:0] A_ADD = 5'h01;
  localparam logic [OPW_DEF-1:0] A_SUB = 5'h02;
  localparam logic [OPW_DEF-1:0] A_AND = 5'h03;
  localparam logic [OPW_DEF-1:0] A_OR  = 5'h04;
  localparam logic [OPW_DEF-1:0] A_XOR = 5'h05;
  localparam logic [OPW_DEF-1:0] A_NOR = 5'h06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Command, register-load and result signals between the upstream sequencer
// (master) and the execute stage (slave).
interface alu_exec_ctrl_if #(
  parameter int DW  = 32,
  parameter int OPW = 5,
  parameter int AW  = 3,
  parameter int CW  = 16
);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_op;
  logic [AW-1:0]  cmd_rd;
  logic [AW-1:0]  cmd_rs;
  logic [AW-1:0]  cmd_rt;

  logic           ld_en;
  logic [AW-1:0]  ld_addr;
  logic [DW-1:0]  ld_data;

  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  res_rd;
  logic [CW-1:0]  done_cnt;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    output ld_en, ld_addr, ld_data,
    input  cmd_ready, res_valid, res_data, res_rd, done_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
    input  ld_en, ld_addr, ld_data,
    output cmd_ready, res_valid, res_data, res_rd, done_cnt
  );

endinterface

// File: rtl/regfile_8x32.sv
// Register file with two combinational read ports and one synchronous write
// port; r0 always reads zero and ignores writes.
module regfile_8x32 #(
  parameter int NREG = 8,
  parameter int DW   = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREG];

  // NOTE: this array is small and must read zero after reset, so it is built
  // from resettable flops; large RAMs are normally left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Operand-fetch / write-back sequencer wrapped around an external
// combinational ALU: IDLE -> RD -> EX -> WB, one command per four cycles.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int OPW  = OPW_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave bus,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out
);

  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [AW-1:0]  rs;
    logic [AW-1:0]  rt;
  } cmd_t;

  state_t        state, state_nx;
  cmd_t          cmd_q;
  logic          armed;
  logic          accept;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [DW-1:0] rd_a, rd_b;
  logic [DW-1:0] res_data_q;
  logic [AW-1:0] res_rd_q;
  logic [CW-1:0] done_q;

  regfile_8x32 #(.NREG(NREG), .DW(DW), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (cmd_q.rs),
    .ra_data (rd_a),
    .rb_addr (cmd_q.rt),
    .rb_data (rd_b),
    .we      (rf_we),
    .wa      (rf_wa),
    .wd      (rf_wd)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no path infers a
  // latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RD;
      RD:   state_nx = EX;
      EX:   state_nx = WB;
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The load port and write-back share the single write port; they live in
  // different states so they never collide.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    rf_we         = 1'b0;
    rf_wa         = bus.ld_addr;
    rf_wd         = bus.ld_data;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = armed;
        rf_we         = bus.ld_en;
      end
      WB: begin
        bus.res_valid = 1'b1;
        rf_we         = (cmd_q.op != A_NOP);
        rf_wa         = res_rd_q;
        rf_wd         = res_data_q;
      end
      default: ;
    endcase
  end

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // armed keeps cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      cmd_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      done_q     <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: if (accept) cmd_q <= '{op: bus.cmd_op, rd: bus.cmd_rd,
                                     rs: bus.cmd_rs, rt: bus.cmd_rt};
        RD: begin
          alu_a  <= rd_a;
          alu_b  <= rd_b;
          alu_op <= cmd_q.op;
        end
        EX: begin
          res_data_q <= alu_out;
          res_rd_q   <= cmd_q.rd;
        end
        WB: done_q <= done_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.res_data = res_data_q;
  assign bus.res_rd   = res_rd_q;
  assign bus.done_cnt = done_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed and randomised commands checked against
// an array-based register model, plus a narrow-counter instance for wrap.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a & b;
      5'd4:    return a | b;
      5'd5:    return a ^ b;
      5'd6:    return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  // Main instance
  alu_exec_ctrl_if #(.CW(16)) bus ();
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  assign alu_out = alu_f(alu_op, alu_a, alu_b);

  alu_exec_ctrl u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  // Narrow-counter instance, used only to exercise done_cnt wrap-around
  alu_exec_ctrl_if #(.CW(4)) bus_w ();
  logic [31:0] w_a, w_b, w_out;
  logic [4:0]  w_op;
  assign w_out = alu_f(w_op, w_a, w_b);

  alu_exec_ctrl #(.CW(4)) u_wrap (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_w),
    .alu_a   (w_a),
    .alu_b   (w_b),
    .alu_op  (w_op),
    .alu_out (w_out)
  );

  // Reference model: architectural registers and completion count
  logic [31:0] ref_rf [8];
  logic [15:0] ref_done;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_rf[i] = 32'h0;
    ref_done = 16'h0;
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    if (addr != 3'd0) ref_rf[addr] = data;
    tick();
    bus.ld_en = 1'b0;
  endtask

  // One full command starting from an IDLE negedge; cmd_valid stays high
  // with junk fields through RD/EX to prove nothing else gets accepted.
  task automatic run_cmd(input logic [4:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt,
                         input bit ld, input logic [2:0] la, input logic [31:0] ldd,
                         input bit ex_ld);
    logic [31:0] a, b, r;
    check("ready_idle", {31'h0, bus.cmd_ready}, 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs    = rs;
    bus.cmd_rt    = rt;
    bus.ld_en     = ld;
    bus.ld_addr   = la;
    bus.ld_data   = ldd;
    if (ld && la != 3'd0) ref_rf[la] = ldd;
    a = ref_rf[rs];
    b = ref_rf[rt];
    r = alu_f(op, a, b);
    tick();  // RD
    check("ready_rd", {31'h0, bus.cmd_ready}, 32'h0);
    bus.ld_en  = 1'b0;
    bus.cmd_op = 5'($urandom);
    bus.cmd_rd = 3'($urandom);
    bus.cmd_rs = 3'($urandom);
    bus.cmd_rt = 3'($urandom);
    tick();  // EX
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", {27'h0, alu_op}, {27'h0, op});
    check("ready_ex", {31'h0, bus.cmd_ready}, 32'h0);
    check("valid_ex", {31'h0, bus.res_valid}, 32'h0);
    if (ex_ld) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = 3'($urandom);
      bus.ld_data = $urandom;
    end
    tick();  // WB
    check("res_valid", {31'h0, bus.res_valid}, 32'h1);
    check("res_data", bus.res_data, r);
    check("res_rd", {29'h0, bus.res_rd}, {29'h0, rd});
    bus.cmd_valid = 1'b0;
    bus.ld_en     = 1'b0;
    if (op != 5'd0 && rd != 3'd0) ref_rf[rd] = r;
    ref_done = ref_done + 16'd1;
    tick();  // IDLE
    check("valid_pulse", {31'h0, bus.res_valid}, 32'h0);
    check("done_cnt", {16'h0, bus.done_cnt}, {16'h0, ref_done});
    check("alu_op_hold", {27'h0, alu_op}, {27'h0, op});
  endtask

  task automatic cmd(input logic [4:0] op, input logic [2:0] rd,
                     input logic [2:0] rs, input logic [2:0] rt);
    run_cmd(op, rd, rs, rt, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs = '0; bus.cmd_rt = '0;
    bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus_w.cmd_valid = 1'b0; bus_w.cmd_op = '0; bus_w.cmd_rd = '0; bus_w.cmd_rs = '0;
    bus_w.cmd_rt = '0; bus_w.ld_en = 1'b0; bus_w.ld_addr = '0; bus_w.ld_data = '0;
    model_reset();
    rst_n = 1'b0;
    #12;
    check("rst_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("rst_valid", {31'h0, bus.res_valid}, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_op", {27'h0, alu_op}, 32'h0);
    check("rst_res_data", bus.res_data, 32'h0);
    check("rst_done", {16'h0, bus.done_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {31'h0, bus.cmd_ready}, 32'h0);
    tick();
    check("ready_after_edge", {31'h0, bus.cmd_ready}, 32'h1);

    // Directed scenarios
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    cmd(A_ADD, 3'd3, 3'd1, 3'd2);            // 8
    cmd(A_SUB, 3'd4, 3'd3, 3'd1);            // 3
    cmd(A_NOR, 3'd5, 3'd0, 3'd0);            // FFFFFFFF
    cmd(A_ADD, 3'd0, 3'd1, 3'd0);            // 5, discarded
    cmd(A_OR,  3'd0, 3'd0, 3'd0);            // r0 reads 0
    load(3'd6, 32'd77);
    cmd(A_NOP, 3'd6, 3'd1, 3'd2);            // 0, suppressed
    cmd(A_OR,  3'd0, 3'd6, 3'd5);            // r6 still 77
    run_cmd(A_AND, 3'd0, 3'd1, 3'd1, 1'b0, 3'd0, 32'h0, 1'b1);  // ld_en in EX ignored
    cmd(A_OR,  3'd0, 3'd1, 3'd2);
    cmd(A_OR,  3'd0, 3'd3, 3'd4);
    cmd(A_OR,  3'd0, 3'd5, 3'd6);
    run_cmd(A_XOR, 3'd7, 3'd7, 3'd7, 1'b1, 3'd7, 32'd9, 1'b0);  // reads 9^9
    cmd(A_OR,  3'd0, 3'd7, 3'd0);
    load(3'd0, 32'd123);
    cmd(A_OR,  3'd0, 3'd0, 3'd0);
    cmd(5'h1F, 3'd4, 3'd1, 3'd2);            // unknown op writes 0
    cmd(A_OR,  3'd0, 3'd4, 3'd1);

    // Randomised commands
    for (int i = 1; i < 8; i++) load(3'(i), $urandom);
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = ($urandom_range(9, 0) == 0) ? 5'h1F : 5'($urandom_range(7, 0));
      run_cmd(op, 3'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom), 3'($urandom), $urandom, 1'($urandom));
    end

    // Reset in the middle of a command
    bus.cmd_valid = 1'b1; bus.cmd_op = A_ADD; bus.cmd_rd = 3'd2;
    bus.cmd_rs = 3'd1; bus.cmd_rt = 3'd3;
    tick(); tick();                          // in EX
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", {31'h0, bus.res_valid}, 32'h0);
    check("mid_rst_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("mid_rst_alu_a", alu_a, 32'h0);
    check("mid_rst_alu_b", alu_b, 32'h0);
    check("mid_rst_res", bus.res_data, 32'h0);
    check("mid_rst_done", {16'h0, bus.done_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
    check("post_rst_valid", {31'h0, bus.res_valid}, 32'h0);
    cmd(A_OR, 3'd0, 3'd1, 3'd2);
    cmd(A_OR, 3'd0, 3'd3, 3'd7);

    // Counter wrap on the 4-bit instance: held cmd_valid -> one NOP per 4 cycles
    bus_w.cmd_valid = 1'b1;
    repeat (4 * 15) tick();
    check("wrap_15", {28'h0, bus_w.done_cnt}, 32'd15);
    repeat (4) tick();
    check("wrap_0", {28'h0, bus_w.done_cnt}, 32'd0);
    repeat (4) tick();
    check("wrap_1", {28'h0, bus_w.done_cnt}, 32'd1);
    bus_w.cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
